// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN to switch arbitration to fixed lowest-index priority.
module alu_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int GNT_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_op_a_i,
    input  logic [NUM_REQ*32-1:0]   req_op_b_i,
    input  logic [NUM_REQ*4-1:0]    req_alu_op_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic [GNT_W-1:0]        rsp_gnt_o,
    output logic [31:0]             alu_operand_a_o,
    output logic [31:0]             alu_operand_b_o,
    output logic [3:0]              alu_op_o,
    input  logic [31:0]             alu_data_i
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("alu_share_arb: NUM_REQ must be in 2..4");
    end
    if ((1 << GNT_W) < NUM_REQ) begin : g_bad_gnt_w
        $error("alu_share_arb: GNT_W too narrow for NUM_REQ");
    end

    state_t               r_state;
    logic [GNT_W-1:0]     r_gnt;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;
    logic [3:0]           r_op;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [31:0]          r_rsp_data;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [GNT_W-1:0]     r_last_gnt;
`endif

    logic                 w_any;
    logic [GNT_W-1:0]     w_gnt;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic [NUM_REQ-1:0]   w_own_oh;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;
    logic [3:0]           w_sel_op;
    logic                 w_rsp_hs;

    // Winner search over currently valid requesters.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_any && req_valid_i[j]) begin
                w_any = 1'b1;
                w_gnt = GNT_W'(j);
            end
        end
`else
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_any && req_valid_i[j] && (j == (int'(r_last_gnt) + i) % NUM_REQ)) begin
                    w_any = 1'b1;
                    w_gnt = GNT_W'(j);
                end
            end
        end
`endif
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (GNT_W'(j) == w_gnt) begin
                w_sel_a  = req_op_a_i[32*j +: 32];
                w_sel_b  = req_op_b_i[32*j +: 32];
                w_sel_op = req_alu_op_i[4*j +: 4];
            end
        end
    end

    assign w_gnt_oh = NUM_REQ'(1) << w_gnt;
    assign w_own_oh = NUM_REQ'(1) << r_gnt;
    assign w_rsp_hs = (r_state == RESP) && |(rsp_ready_i & w_own_oh);

    // Ready is gated by reset so every output reads 0 while rst_ni is low.
    assign req_ready_o = (rst_ni && r_state == IDLE && w_any) ? w_gnt_oh : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op        <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_gnt  <= GNT_W'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_gnt   <= w_gnt;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu_data_i;
                    r_rsp_valid <= w_own_oh;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_gnt  <= r_gnt;
`endif
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_data_o      = r_rsp_data;
    assign rsp_gnt_o       = r_gnt;
    assign alu_operand_a_o = r_op_a;
    assign alu_operand_b_o = r_op_b;
    assign alu_op_o        = r_op;

endmodule
